branch_predictor: RTL and testbench

- Parametrised dynamic branch predictor for the IF stage; replaces the fixed single-bit prediction with a direct-mapped branch target buffer (BTB) and per-entry saturating counters.
- Lookup is combinational on the fetch PC, in the same cycle that the ROM address is presented.
- Update comes from EX-stage branch resolution.
- Also provides saturating branch and misprediction statistics counters for the didactic platform.

---
 rtl/branch_predictor.sv | 152 +++++++++++++++
 tb/tb_branch_predictor.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters for the IF stage.
// Lookup is combinational on the fetch PC. Updates come from EX-stage
// resolution. Also keeps saturating branch / misprediction statistics.

// One BTB entry. It decides locally whether an update hits or allocates.
module branch_predictor_entry #(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 26,
  parameter int CNT_BITS = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_sel,     // update addressed to this entry
  input  logic             i_inval,   // fence.i clear, overrides i_sel
  input  logic             i_taken,
  input  logic [TAG_W-1:0] i_tag,
  input  logic [XLEN-1:0]  i_target,
  output logic             o_valid,
  output logic [TAG_W-1:0] o_tag,
  output logic [XLEN-1:0]  o_target,
  output logic             o_cnt_msb
);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1 << (CNT_BITS-1));
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'((1 << (CNT_BITS-1)) - 1);

  logic                r_valid;
  logic [TAG_W-1:0]    r_tag;
  logic [XLEN-1:0]     r_target;
  logic [CNT_BITS-1:0] r_cnt;
  logic                w_hit;

  assign w_hit = r_valid && (r_tag == i_tag);

  // Entry state: invalidate drops the whole update, hits train, taken misses allocate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid  <= 1'b0;
      r_tag    <= '0;
      r_target <= '0;
      r_cnt    <= CNT_WNT;
    end else if (i_inval) begin
      r_valid <= 1'b0;
    end else if (i_sel) begin
      if (w_hit) begin
        if (i_taken) begin
          r_target <= i_target;
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_BITS'(1);
        end else if (r_cnt != '0) begin
          r_cnt <= r_cnt - CNT_BITS'(1);
        end
      end else if (i_taken) begin
        r_valid  <= 1'b1;
        r_tag    <= i_tag;
        r_target <= i_target;
        r_cnt    <= CNT_WT;
      end
    end
  end

  assign o_valid   = r_valid;
  assign o_tag     = r_tag;
  assign o_target  = r_target;
  assign o_cnt_msb = r_cnt[CNT_BITS-1];
endmodule

module branch_predictor #(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 16,
  parameter int CNT_BITS  = 2,
  parameter int PRED_MODE = 1,
  parameter int STAT_W    = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [XLEN-1:0]   fetch_pc_i,
  output logic              hit_o,
  output logic              pred_taken_o,
  output logic [XLEN-1:0]   next_pc_o,
  input  logic              upd_valid_i,
  input  logic [XLEN-1:0]   upd_pc_i,
  input  logic              upd_taken_i,
  input  logic [XLEN-1:0]   upd_target_i,
  input  logic              upd_mispred_i,
  input  logic              invalidate_i,
  output logic [STAT_W-1:0] branch_cnt_o,
  output logic [STAT_W-1:0] mispred_cnt_o
);
  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 2;

  logic [IDX-1:0]                  w_fetch_idx, w_upd_idx;
  logic [TAG_W-1:0]                w_fetch_tag, w_upd_tag;
  logic [ENTRIES-1:0]              w_sel;
  logic [ENTRIES-1:0]              w_valid;
  logic [ENTRIES-1:0]              w_cnt_msb;
  logic [ENTRIES-1:0][TAG_W-1:0]   w_tag;
  logic [ENTRIES-1:0][XLEN-1:0]    w_target;
  logic [STAT_W-1:0]               r_branch_cnt, r_mispred_cnt;
  logic                            w_unused_lsbs;

  // Byte-offset bits never take part in indexing or tagging.
  assign w_unused_lsbs = ^{fetch_pc_i[1:0], upd_pc_i[1:0]};

  assign w_fetch_idx = fetch_pc_i[IDX+1:2];
  assign w_fetch_tag = fetch_pc_i[XLEN-1:IDX+2];
  assign w_upd_idx   = upd_pc_i[IDX+1:2];
  assign w_upd_tag   = upd_pc_i[XLEN-1:IDX+2];

  genvar g;
  generate
    for (g = 0; g < ENTRIES; g++) begin : g_ent
      assign w_sel[g] = upd_valid_i && (w_upd_idx == IDX'(g));
      branch_predictor_entry #(
        .XLEN(XLEN), .TAG_W(TAG_W), .CNT_BITS(CNT_BITS)
      ) u_ent (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_sel    (w_sel[g]),
        .i_inval  (invalidate_i),
        .i_taken  (upd_taken_i),
        .i_tag    (w_upd_tag),
        .i_target (upd_target_i),
        .o_valid  (w_valid[g]),
        .o_tag    (w_tag[g]),
        .o_target (w_target[g]),
        .o_cnt_msb(w_cnt_msb[g])
      );
    end
  endgenerate

  // Zero-latency lookup; reads pre-update contents when an update targets the same entry.
  always_comb begin
    hit_o        = w_valid[w_fetch_idx] && (w_tag[w_fetch_idx] == w_fetch_tag);
    pred_taken_o = (PRED_MODE != 0) && hit_o && w_cnt_msb[w_fetch_idx];
    next_pc_o    = pred_taken_o ? w_target[w_fetch_idx] : fetch_pc_i + XLEN'(4);
  end

  // Statistics: saturating, counted even when invalidate drops the table write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else if (upd_valid_i) begin
      if (r_branch_cnt != '1) r_branch_cnt <= r_branch_cnt + STAT_W'(1);
      if (upd_mispred_i && (r_mispred_cnt != '1)) r_mispred_cnt <= r_mispred_cnt + STAT_W'(1);
    end
  end

  assign branch_cnt_o  = r_branch_cnt;
  assign mispred_cnt_o = r_mispred_cnt;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: the driver pushes expected lookup/statistics values per
// cycle, a negedge monitor pops and compares. Two DUTs share stimulus: a
// dynamic build and a static not-taken build.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] fetch_pc, upd_pc, upd_target;
  logic        upd_valid, upd_taken, upd_mispred, invalidate;
  logic        hit1, pred1, hit0, pred0;
  logic [31:0] next1, next0, bcnt1, mcnt1, bcnt0, mcnt0;

  always #5 clk = ~clk;

  branch_predictor #(.PRED_MODE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .fetch_pc_i(fetch_pc),
    .hit_o(hit1), .pred_taken_o(pred1), .next_pc_o(next1),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_mispred_i(upd_mispred),
    .invalidate_i(invalidate), .branch_cnt_o(bcnt1), .mispred_cnt_o(mcnt1));

  branch_predictor #(.PRED_MODE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .fetch_pc_i(fetch_pc),
    .hit_o(hit0), .pred_taken_o(pred0), .next_pc_o(next0),
    .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
    .upd_target_i(upd_target), .upd_mispred_i(upd_mispred),
    .invalidate_i(invalidate), .branch_cnt_o(bcnt0), .mispred_cnt_o(mcnt0));

  typedef struct {
    logic        hit, pred;
    logic [31:0] next1, next0, bcnt, mcnt;
  } exp_t;
  exp_t q[$];

  int tests = 0, fails = 0;

  // Reference model: a 16-entry table addressed by word index, 2-bit counters.
  bit          m_valid[16];
  int unsigned m_tag[16], m_tgt[16], m_cnt[16];
  longint      m_b, m_m;

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
    end
    m_b = 0; m_m = 0;
  endfunction

  function automatic exp_t m_lookup(input logic [31:0] pc);
    exp_t e;
    int unsigned idx;
    idx     = (pc / 4) % 16;
    e.hit   = m_valid[idx] && (m_tag[idx] == pc / 64);
    e.pred  = e.hit && (m_cnt[idx] >= 2);
    e.next1 = e.pred ? m_tgt[idx] : pc + 32'd4;
    e.next0 = pc + 32'd4;
    e.bcnt  = 32'(m_b);
    e.mcnt  = 32'(m_m);
    return e;
  endfunction

  function automatic void m_update(input bit uv, input logic [31:0] pc, input bit tk,
                                   input logic [31:0] tgt, input bit mis, input bit inv);
    int unsigned idx;
    bit h;
    if (uv) begin
      if (m_b < 64'hFFFF_FFFF) m_b++;
      if (mis && m_m < 64'hFFFF_FFFF) m_m++;
    end
    if (inv) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 0;
      return;
    end
    if (!uv) return;
    idx = (pc / 4) % 16;
    h   = m_valid[idx] && (m_tag[idx] == pc / 64);
    if (h) begin
      if (tk) begin
        m_tgt[idx] = tgt;
        if (m_cnt[idx] < 3) m_cnt[idx]++;
      end else if (m_cnt[idx] > 0) m_cnt[idx]--;
    end else if (tk) begin
      m_valid[idx] = 1; m_tag[idx] = pc / 64; m_tgt[idx] = tgt; m_cnt[idx] = 2;
    end
  endfunction

  // One cycle of stimulus: drive after the edge, record what the lookup must show now.
  task automatic cyc(input bit rst, input logic [31:0] fpc, input bit uv,
                     input logic [31:0] upc, input bit tk, input logic [31:0] tgt,
                     input bit mis, input bit inv);
    @(posedge clk); #1;
    reset_n = !rst; fetch_pc = fpc; upd_valid = uv; upd_pc = upc;
    upd_taken = tk; upd_target = tgt; upd_mispred = mis; invalidate = inv;
    if (rst) m_reset();
    q.push_back(m_lookup(fpc));
    if (!rst) m_update(uv, upc, tk, tgt, mis, inv);
  endtask

  task automatic fetch(input logic [31:0] fpc);
    cyc(0, fpc, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    cyc(0, 32'h0, 1, pc, tk, tgt, 0, 0);
  endtask

  // Reset dropped mid-cycle with an update pending; outputs must clear before any edge.
  task automatic async_reset();
    @(posedge clk); #1;
    reset_n = 1; fetch_pc = 32'h100; upd_valid = 1; upd_pc = 32'h100;
    upd_taken = 1; upd_target = 32'h77C; upd_mispred = 1; invalidate = 0;
    #1 reset_n = 0;
    m_reset();
    q.push_back(m_lookup(32'h100));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every negedge with a pending expectation, compare both DUTs.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("hit",   32'(hit1),  32'(e.hit));
      chk("pred",  32'(pred1), 32'(e.pred));
      chk("next",  next1,      e.next1);
      chk("bcnt",  bcnt1,      e.bcnt);
      chk("mcnt",  mcnt1,      e.mcnt);
      chk("hit_static",  32'(hit0),  32'(e.hit));
      chk("pred_static", 32'(pred0), 32'h0);
      chk("next_static", next0,      e.next0);
      chk("bcnt_static", bcnt0,      e.bcnt);
    end
  end

  logic [31:0] pool [8];

  initial begin
    reset_n = 0; fetch_pc = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0;
    upd_target = 0; upd_mispred = 0; invalidate = 0;
    pool = '{32'h100, 32'h140, 32'h200, 32'h300, 32'h104, 32'h1100, 32'hFFFF_FFFC, 32'h23C};

    cyc(1, 32'h100, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h100, 0, 0, 0, 0, 0, 0);
    // allocate 0x100 -> 0x40, seen next cycle only
    cyc(0, 32'h100, 1, 32'h100, 1, 32'h40, 1, 0);
    fetch(32'h100);
    // not-taken training down to saturation at 0
    upd(32'h100, 0, 32'h0);
    upd(32'h100, 0, 32'h0);
    upd(32'h100, 0, 32'h0);
    fetch(32'h100);
    for (int i = 0; i < 4; i++) upd(32'h100, 1, 32'h40);
    fetch(32'h100);
    // aliasing: same index, different tag
    upd(32'h140, 1, 32'h80);
    fetch(32'h100);
    fetch(32'h140);
    // same-cycle lookup and update
    cyc(0, 32'h200, 1, 32'h200, 1, 32'h500, 0, 0);
    fetch(32'h200);
    // invalidate beats allocation, stats still count
    cyc(0, 32'h140, 1, 32'h300, 1, 32'h600, 1, 1);
    fetch(32'h300);
    fetch(32'h140);
    // PC increment wraps
    fetch(32'hFFFF_FFFC);
    upd(32'hFFFF_FFFC, 1, 32'h10);
    fetch(32'hFFFF_FFFC);

    // randomized traffic over a small aliasing address pool
    for (int n = 0; n < 400; n++) begin
      cyc(0, pool[$urandom_range(0, 7)], 1'($urandom_range(0, 3) != 0),
          pool[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
          $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 40) == 0));
    end

    async_reset();
    fetch(32'h100);
    upd(32'h100, 1, 32'h90);
    fetch(32'h100);

    for (int w = 0; w < 20 && q.size() > 0; w++) @(posedge clk);
    @(posedge clk);
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
